// File: rtl/uart_tx_fifo_if.sv
// Core-side store path and transmitter handshake of the UART transmit FIFO.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          clr_overflow;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    // Core store path plus UART transmitter side, as seen by whoever drives the FIFO.
    modport master (
        output wr_en, wr_data, clr_overflow, tx_ready,
        input  full, count, overflow, tx_data, tx_valid
    );

    // The FIFO itself.
    modport slave (
        input  wr_en, wr_data, clr_overflow, tx_ready,
        output full, count, overflow, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: buffers bytes stored by the core and offers them to the
// transmitter first-word fall-through. A write into a full FIFO is dropped
// unless a pop happens on the same edge; drops raise a sticky overflow flag.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_fifo_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Handshake decode; a pop frees the slot a same-cycle write needs.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == FULL_CNT);
        w_pop   = !w_empty && bus.tx_ready;
        w_push  = bus.wr_en && (!w_full || w_pop);
        w_drop  = bus.wr_en && w_full && !w_pop;
    end

    // Storage array; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wptr] <= bus.wr_data;
    end

    // Pointers wrap naturally at AW bits because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
        else if (bus.clr_overflow)
            r_overflow <= 1'b0;
    end

    // All outputs come from registers only, so no input reaches them in-cycle.
    always_comb begin
        bus.full     = w_full;
        bus.count    = r_count;
        bus.overflow = r_overflow;
        bus.tx_valid = !w_empty;
        bus.tx_data  = r_mem[r_rptr];
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH, 8, number of byte entries; SHALL be a power of two, at least 2.
- AW, log2(DEPTH), pointer width; derived, never overridden.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, synchronous reset, active-high.
- wr_en, in, 1, core store to the UART transmit address, from the store-path write enable.
- wr_data, in, 8, store data byte, low byte of the store-path data.
- full, out, 1, FIFO holds DEPTH entries; drives the core-visible transmit-ready status bit as ~full.
- count, out, AW+1, current occupancy, 0..DEPTH.
- overflow, out, 1, sticky flag: a write was dropped.
- clr_overflow, in, 1, clears overflow.
- tx_data, out, 8, byte offered to the UART transmitter.
- tx_valid, out, 1, tx_data is valid.
- tx_ready, in, 1, UART transmitter accepts a byte.

Function
REQ-003 The block SHALL store up to DEPTH bytes in arrival order and present them to the transmitter first-in first-out.
REQ-004 Pop: tx_valid & tx_ready in a cycle pops exactly one entry at that clock edge.
REQ-005 Push: wr_en is accepted when count < DEPTH, or when a pop occurs in the same cycle.
REQ-006 Dropped write: wr_en with count == DEPTH and no pop SHALL discard the byte and leave all FIFO contents unchanged.
REQ-007 tx_valid SHALL equal (count != 0); tx_data SHALL equal the oldest entry (first-word fall-through, no combinational input-to-output path).
REQ-008 Write into an empty FIFO: tx_valid rises the cycle after the wr_en cycle, never in the same cycle.
REQ-009 count update per edge:
- +1 on accepted push without pop.
- -1 on pop without push.
- unchanged on simultaneous push and pop, or on neither.
REQ-010 full SHALL equal (count == DEPTH); empty is internal only and equals (count == 0).
REQ-011 Write and read pointers SHALL be AW bits and wrap modulo DEPTH, from DEPTH-1 to 0, with no bubble.
REQ-012 overflow SHALL be set on the edge following any dropped write (REQ-006) and held until cleared.
REQ-013 clr_overflow SHALL clear overflow on the next edge; if a dropped write occurs in the same cycle, set wins and overflow stays 1.
REQ-014 A tx_ready pulse while empty SHALL have no effect: count stays 0 and pointers do not move.
REQ-015 tx_data and tx_valid SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-016 Storage may be a register array; no reset of the data contents is required.

Reset
REQ-017 While rst=1 on an edge:
- pointers and count SHALL become 0, and overflow 0.
- full and tx_valid SHALL be 0 in the following cycle.
REQ-018 wr_en and tx_ready asserted in a reset cycle SHALL be ignored.
REQ-019 Reset asserted mid-operation SHALL discard all queued bytes; after reset deasserts, the first byte presented is the first byte written after reset.
REQ-020 tx_data after reset is don't-care while tx_valid=0.

Verification
REQ-021 Basic order: DEPTH=8, tx_ready=0, write 0x41,0x42,0x43 on consecutive cycles -> count=3, tx_valid=1, tx_data=0x41; then tx_ready=1 for 3 cycles -> bytes 0x41,0x42,0x43 in order, count=0, tx_valid=0.
REQ-022 Full/overflow: tx_ready=0, write 0x00..0x08 (9 writes) -> full=1 after the 8th, 9th byte dropped, overflow=1, count=8; drain -> 0x00..0x07 only; pulse clr_overflow -> overflow=0.
REQ-023 Push and pop at full: count=8, tx_ready=1, wr_en=1 with 0xAA in the same cycle -> count stays 8, overflow stays 0, 0xAA emerges 8th in the drain.
REQ-024 Wrap-around: stream 20 bytes 0x10..0x23 with tx_ready toggling 1/0 each cycle -> output sequence exact and in order, never a spurious tx_valid while count=0.
REQ-025 Reset mid-stream: queue 5 bytes, assert rst for 1 cycle -> count=0, tx_valid=0, overflow=0; then write 0x55 -> tx_data=0x55 one cycle later.
REQ-026 Clear collision: count=8, tx_ready=0, clr_overflow=1 and wr_en=1 in the same cycle -> overflow=1 afterward.
